// File: rtl/la_wb_bridge_pkg.sv
// Shared FSM states and constants for the LA-to-Wishbone bridge.
package la_wb_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [31:0] ERR_RDATA       = 32'hFFFF_FFFF;
   localparam int unsigned TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/la_wb_bridge_if.sv
// Wishbone master-side bus between the bridge and the fwpayload wba_* slave port.
interface la_wb_bridge_if;

   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic        wbm_ack_i;
   logic [31:0] wbm_dat_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_ack_i, wbm_dat_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_ack_i, wbm_dat_i
   );

endinterface

// File: rtl/la_tgl_sync.sv
// Two-flop synchronizer for the LA request toggle plus a history flop;
// req is high for one cycle per level change of tgl.
module la_tgl_sync (
   input  logic wb_clk_i,
   input  logic wb_rst_ni,
   input  logic tgl,
   output logic req
);

   logic tgl_p0, tgl_p1, tgl_p2;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         tgl_p0 <= 1'b0;
         tgl_p1 <= 1'b0;
         tgl_p2 <= 1'b0;
      end else begin
         tgl_p0 <= tgl;
         tgl_p1 <= tgl_p0;
         tgl_p2 <= tgl_p1;
      end
   end

   assign req = tgl_p1 ^ tgl_p2;

endmodule

// File: rtl/la_wb_bridge.sv
// Turns LA request toggles into single Wishbone transfers and reports completion by toggle.
// Optional bus timeout enabled by defining LA_WB_BRIDGE_TIMEOUT_EN.
module la_wb_bridge
   import la_wb_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic           wb_clk_i,
   input  logic           wb_rst_ni,
   input  logic           req_tgl_i,
   input  logic           req_we_i,
   input  logic [3:0]     req_sel_i,
   input  logic [31:0]    req_adr_i,
   input  logic [31:0]    req_dat_i,
   la_wb_bridge_if.master wbm,
   output logic           rsp_tgl_o,
   output logic [31:0]    rsp_dat_o,
   output logic           rsp_err_o,
   output logic           busy_o,
   output logic           ovr_o
);

   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
      $error("la_wb_bridge: TIMEOUT_CYC must be in 1..255");
   end

   state_e state, state_nxt;
   logic   req_det, pend;
   logic   launch, ack_done, to_done, to_hit;

   la_tgl_sync u_sync (
      .wb_clk_i (wb_clk_i),
      .wb_rst_ni(wb_rst_ni),
      .tgl      (req_tgl_i),
      .req      (req_det)
   );

`ifdef LA_WB_BRIDGE_TIMEOUT_EN
   localparam logic [8:0] TO_LIMIT = 9'(TIMEOUT_CYC);
   logic [7:0] to_cnt;

   // to_cnt holds the number of BUS cycles already completed
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni)           to_cnt <= 8'd0;
      else if (state == ST_BUS) to_cnt <= to_cnt + 8'd1;
      else                      to_cnt <= 8'd0;
   end

   assign to_hit = (({1'b0, to_cnt} + 9'd1) == TO_LIMIT);

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni)    rsp_err_o <= 1'b0;
      else if (ack_done) rsp_err_o <= 1'b0;
      else if (to_done)  rsp_err_o <= 1'b1;
   end
`else
   assign to_hit    = 1'b0;
   assign rsp_err_o = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   // Ack is checked before the timeout so a last-cycle ack completes normally
   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      ack_done  = 1'b0;
      to_done   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_det || pend) begin
               launch    = 1'b1;
               state_nxt = ST_BUS;
            end
         end
         ST_BUS: begin
            if (wbm.wbm_ack_i) begin
               ack_done  = 1'b1;
               state_nxt = ST_DONE;
            end else if (to_hit) begin
               to_done   = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // In IDLE a queued request is issued; a coincident new one takes its place
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         pend  <= 1'b0;
         ovr_o <= 1'b0;
      end else if (state == ST_IDLE) begin
         pend <= pend & req_det;
      end else if (req_det) begin
         if (pend) ovr_o <= 1'b1;
         else      pend  <= 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wbm.wbm_cyc_o <= 1'b0;
         wbm.wbm_stb_o <= 1'b0;
         wbm.wbm_we_o  <= 1'b0;
         wbm.wbm_sel_o <= 4'd0;
         wbm.wbm_adr_o <= 32'd0;
         wbm.wbm_dat_o <= 32'd0;
      end else if (launch) begin
         wbm.wbm_cyc_o <= 1'b1;
         wbm.wbm_stb_o <= 1'b1;
         wbm.wbm_we_o  <= req_we_i;
         wbm.wbm_sel_o <= req_sel_i;
         wbm.wbm_adr_o <= req_adr_i;
         wbm.wbm_dat_o <= req_dat_i;
      end else if (ack_done || to_done) begin
         wbm.wbm_cyc_o <= 1'b0;
         wbm.wbm_stb_o <= 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         rsp_dat_o <= 32'd0;
         rsp_tgl_o <= 1'b0;
      end else begin
         if (ack_done && !wbm.wbm_we_o) rsp_dat_o <= wbm.wbm_dat_i;
         else if (to_done)              rsp_dat_o <= ERR_RDATA;
         if (state == ST_DONE)          rsp_tgl_o <= ~rsp_tgl_o;
      end
   end

   assign busy_o = (state != ST_IDLE) || pend;

endmodule

// File: tb/tb_la_wb_bridge.sv
// Bench for la_wb_bridge: vector table, randomized transfers against a transaction-level model,
// and hand sequences for queueing, overrun, timeout and reset corners.
`timescale 1ns/1ps
module tb_la_wb_bridge;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_tgl = 1'b0;
   logic        req_we = 1'b0;
   logic [3:0]  req_sel = 4'd0;
   logic [31:0] req_adr = 32'd0;
   logic [31:0] req_dat = 32'd0;
   logic        rsp_tgl, rsp_err, busy, ovr;
   logic [31:0] rsp_dat;

   la_wb_bridge_if wbif ();

   la_wb_bridge #(.TIMEOUT_CYC(TO)) dut (
      .wb_clk_i (clk),
      .wb_rst_ni(rst_n),
      .req_tgl_i(req_tgl),
      .req_we_i (req_we),
      .req_sel_i(req_sel),
      .req_adr_i(req_adr),
      .req_dat_i(req_dat),
      .wbm      (wbif),
      .rsp_tgl_o(rsp_tgl),
      .rsp_dat_o(rsp_dat),
      .rsp_err_o(rsp_err),
      .busy_o   (busy),
      .ovr_o    (ovr)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Transaction-level model: completion parity, last response data and error flag
   logic        m_tgl = 1'b0;
   logic [31:0] m_rsp = 32'd0;
   logic        m_err = 1'b0;

   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
      int          dly;
      logic [31:0] rdat;
      logic [31:0] exp_rsp;
      logic        exp_err;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Waits for the transfer, checks the bus fields, acks after dly extra cycles
   // (or lets it time out) and checks the completion against the model.
   task automatic serve(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat, input int dly, input logic [31:0] rdat,
                        input logic exp_to);
      int n = 0;
      while (wbif.wbm_stb_o !== 1'b1 && n < 12) begin
         @(negedge clk);
         n++;
      end
      chk("stb_seen", {31'd0, wbif.wbm_stb_o}, 32'd1);
      if (wbif.wbm_stb_o !== 1'b1) return;
      chk("cyc", {31'd0, wbif.wbm_cyc_o}, 32'd1);
      chk("we", {31'd0, wbif.wbm_we_o}, {31'd0, we});
      chk("sel", {28'd0, wbif.wbm_sel_o}, {28'd0, sel});
      chk("adr", wbif.wbm_adr_o, adr);
      chk("dat", wbif.wbm_dat_o, dat);
      chk("busy_bus", {31'd0, busy}, 32'd1);
      if (exp_to) begin
         n = 0;
         while (wbif.wbm_stb_o === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("to_len", 32'(n), 32'(TO));
      end else begin
         for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("hold_stb", {31'd0, wbif.wbm_stb_o}, 32'd1);
            chk("hold_adr", wbif.wbm_adr_o, adr);
         end
         wbif.wbm_ack_i = 1'b1;
         wbif.wbm_dat_i = rdat;
         @(negedge clk);
         wbif.wbm_ack_i = 1'b0;
         wbif.wbm_dat_i = $urandom;
         chk("stb_drop", {31'd0, wbif.wbm_stb_o}, 32'd0);
      end
      chk("tgl_early", {31'd0, rsp_tgl}, {31'd0, m_tgl});
      m_tgl = ~m_tgl;
      if (exp_to) begin
         m_rsp = 32'hFFFF_FFFF;
         m_err = 1'b1;
      end else begin
         if (!we) m_rsp = rdat;
         m_err = 1'b0;
      end
      @(negedge clk);
      chk("rsp_tgl", {31'd0, rsp_tgl}, {31'd0, m_tgl});
      chk("rsp_dat", rsp_dat, m_rsp);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
   endtask

   task automatic do_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, input int dly, input logic [31:0] rdat,
                         input logic exp_to);
      @(negedge clk);
      req_we  = we;
      req_sel = sel;
      req_adr = adr;
      req_dat = dat;
      req_tgl = ~req_tgl;
      serve(we, sel, adr, dat, dly, rdat, exp_to);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      req_tgl = 1'b0;
      wbif.wbm_ack_i = 1'b0;
      #1;
      chk("rst_cyc", {31'd0, wbif.wbm_cyc_o}, 32'd0);
      chk("rst_stb", {31'd0, wbif.wbm_stb_o}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      m_tgl = 1'b0;
      m_rsp = 32'd0;
      m_err = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      wbif.wbm_ack_i = 1'b0;
      wbif.wbm_dat_i = 32'd0;

      tbl[0] = '{1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_5A5A, 1, 32'h0,         32'h0000_0000, 1'b0};
      tbl[1] = '{1'b0, 4'hF, 32'h3000_0008, 32'h0,         3, 32'h1234_5678, 32'h1234_5678, 1'b0};
      tbl[2] = '{1'b1, 4'h3, 32'h3000_0010, 32'h0,         0, 32'h0,         32'h1234_5678, 1'b0};
      tbl[3] = '{1'b0, 4'hF, 32'h3000_000C, 32'h0,         0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
      tbl[4] = '{1'b0, 4'h1, 32'h3000_0000, 32'h0,         2, 32'h0000_0001, 32'h0000_0001, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_cyc", {31'd0, wbif.wbm_cyc_o}, 32'd0);
      chk("rst_stb", {31'd0, wbif.wbm_stb_o}, 32'd0);
      chk("rst_adr", wbif.wbm_adr_o, 32'd0);
      chk("rst_sel", {28'd0, wbif.wbm_sel_o}, 32'd0);
      chk("rst_tgl", {31'd0, rsp_tgl}, 32'd0);
      chk("rst_rdat", rsp_dat, 32'd0);
      chk("rst_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ovr", {31'd0, ovr}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // Vector table
      for (int i = 0; i < 5; i++) begin
         do_txn(tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].dat, tbl[i].dly, tbl[i].rdat, 1'b0);
         chk("tbl_rsp", rsp_dat, tbl[i].exp_rsp);
         chk("tbl_err", {31'd0, rsp_err}, {31'd0, tbl[i].exp_err});
      end

      // Stray ack while idle must be ignored
      @(negedge clk);
      wbif.wbm_ack_i = 1'b1;
      wbif.wbm_dat_i = 32'hCAFE_F00D;
      repeat (2) @(negedge clk);
      wbif.wbm_ack_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("stray_tgl", {31'd0, rsp_tgl}, {31'd0, m_tgl});
      chk("stray_dat", rsp_dat, m_rsp);
      chk("stray_busy", {31'd0, busy}, 32'd0);
      chk("stray_stb", {31'd0, wbif.wbm_stb_o}, 32'd0);

`ifdef LA_WB_BRIDGE_TIMEOUT_EN
      do_txn(1'b0, 4'hF, 32'h3000_0020, 32'h0, 0, 32'h0, 1'b1);
      chk("to_dat", rsp_dat, 32'hFFFF_FFFF);
      chk("to_err", {31'd0, rsp_err}, 32'd1);
      do_txn(1'b0, 4'hF, 32'h3000_0024, 32'h0, TO - 1, 32'h0000_55AA, 1'b0);
      chk("to_edge_err", {31'd0, rsp_err}, 32'd0);
      chk("to_edge_dat", rsp_dat, 32'h0000_55AA);
`else
      do_txn(1'b0, 4'hF, 32'h3000_0020, 32'h0, 12, 32'h0BAD_CAFE, 1'b0);
      chk("long_err", {31'd0, rsp_err}, 32'd0);
`endif

      // Randomized transfers against the model
      for (int i = 0; i < 24; i++) begin
         logic        r_we;
         logic [3:0]  r_sel;
         logic [31:0] r_adr, r_dat, r_rd;
         r_we  = 1'($urandom_range(0, 1));
         r_sel = 4'($urandom);
         r_adr = $urandom;
         r_dat = $urandom;
         r_rd  = $urandom;
         do_txn(r_we, r_sel, r_adr, r_dat, $urandom_range(0, TO - 1), r_rd, 1'b0);
      end

      // Two extra requests during one transfer: first queued, second dropped
      @(negedge clk);
      req_we = 1'b1; req_sel = 4'hC; req_adr = 32'h3000_0040; req_dat = 32'h1111_2222;
      req_tgl = ~req_tgl;
      begin
         int n = 0;
         while (wbif.wbm_stb_o !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
         end
      end
      chk("b2b_stb", {31'd0, wbif.wbm_stb_o}, 32'd1);
      chk("b2b_adr", wbif.wbm_adr_o, 32'h3000_0040);
      req_tgl = ~req_tgl;
      @(negedge clk);
      req_tgl = ~req_tgl;
      @(negedge clk);
      chk("b2b_hold", wbif.wbm_dat_o, 32'h1111_2222);
      @(negedge clk);
      wbif.wbm_ack_i = 1'b1;
      @(negedge clk);
      wbif.wbm_ack_i = 1'b0;
      chk("b2b_ovr", {31'd0, ovr}, 32'd1);
      chk("b2b_drop", {31'd0, wbif.wbm_stb_o}, 32'd0);
      req_we = 1'b0; req_sel = 4'h5; req_adr = 32'h3000_0044; req_dat = 32'h3333_4444;
      m_tgl = ~m_tgl;
      m_err = 1'b0;
      @(negedge clk);
      chk("b2b_tgl1", {31'd0, rsp_tgl}, {31'd0, m_tgl});
      chk("b2b_pend_busy", {31'd0, busy}, 32'd1);
      serve(1'b0, 4'h5, 32'h3000_0044, 32'h3333_4444, 1, 32'h7777_8888, 1'b0);
      repeat (8) @(negedge clk);
      chk("b2b_no_third", {31'd0, rsp_tgl}, {31'd0, m_tgl});
      chk("b2b_idle", {31'd0, busy}, 32'd0);
      chk("b2b_ovr_sticky", {31'd0, ovr}, 32'd1);

      // Reset clears the sticky overrun, then a reset mid-transfer abandons it
      do_reset();
      @(negedge clk);
      chk("rst2_ovr", {31'd0, ovr}, 32'd0);
      chk("rst2_tgl", {31'd0, rsp_tgl}, 32'd0);
      chk("rst2_dat", rsp_dat, 32'd0);
      @(negedge clk);
      req_we = 1'b1; req_sel = 4'hF; req_adr = 32'h3000_0050; req_dat = 32'h5555_6666;
      req_tgl = ~req_tgl;
      begin
         int n = 0;
         while (wbif.wbm_stb_o !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
         end
      end
      chk("mid_stb", {31'd0, wbif.wbm_stb_o}, 32'd1);
      do_reset();
      repeat (5) @(negedge clk);
      chk("mid_tgl", {31'd0, rsp_tgl}, 32'd0);
      chk("mid_busy", {31'd0, busy}, 32'd0);
      chk("mid_stb_low", {31'd0, wbif.wbm_stb_o}, 32'd0);
      do_txn(1'b0, 4'hA, 32'h3000_0060, 32'h0, 1, 32'h9999_AAAA, 1'b0);
      chk("post_rst_dat", rsp_dat, 32'h9999_AAAA);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
